id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  Decode-to-execute pipeline register of the 5-stage RV32I core. Captures decoded
//  control (ex, jump_t, slt, lui, write enables, result select) and operand data from ID,
//  and presents them to the EX stage: the EX control decoder, ALU muxes and branch logic.
//  Implements stall (hold) and flush (bubble) from the hazard unit and tracks a valid bit.
// PARAMETERS
//  XLEN        32  datapath width (PC, operands, immediate)
//  RADDR_W     5   register-file address width
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  stall          in   1        hold current contents (hazard unit, load-use)
//  flush          in   1        replace next contents with bubble (taken branch/jump)
//  id_valid       in   1        ID holds a real instruction
//  id_pc          in   XLEN     PC of ID instruction
//  id_pc_plus4    in   XLEN     PC+4 of ID instruction
//  id_rd1/id_rd2  in   XLEN     register-file read data
//  id_imm         in   XLEN     sign-extended immediate
//  id_rs1/id_rs2  in   RADDR_W  source register addresses (forwarding)
//  id_rd          in   RADDR_W  destination register address
//  id_ex          in   3        ALU op code; bit2 = ALU B-source select
//  id_jump_t      in   2        00 none, 01 JAL, 10 JALR, 11 BRANCH
//  id_slt/id_lui  in   1        result-select qualifiers for EX
//  id_reg_write   in   1        writes rd
//  id_mem_write   in   1        store
//  id_result_src  in   2        00 ALU, 01 mem, 10 PC+4
//  ex_*           out  (same)   registered copy of every id_* above
//  ex_valid       out  1        EX holds a real instruction
// BEHAVIOUR
//  - rst_n low (async): all ex_* = 0, ex_valid = 0 immediately; release synchronous to clk.
//  - Latency 1 cycle. Per rising edge, priority: flush > stall > load.
//  - flush=1: bubble -> ex_valid=0, ex_reg_write=0, ex_mem_write=0, ex_jump_t=00,
//    ex_ex=000, ex_slt=0, ex_lui=0, ex_result_src=00; all data/address fields = 0.
//  - flush=1 & stall=1 same cycle: flush wins (bubble loaded, no hold).
//  - stall=1, flush=0: every output holds its value, including ex_valid.
//  - load with id_valid=0: bubble exactly as flush (control zeroed, data zeroed).
//  - load with id_valid=1: all ex_* <= id_*; ex_valid=1.
//  - Invariant: ex_valid=0 implies ex_reg_write=0, ex_mem_write=0, ex_jump_t=00;
//    bubbles must never write state or redirect the PC.
//  - No arithmetic; widths pass straight through, no truncation/extension.
//  - Stall sustained N cycles: contents unchanged N cycles, load resumes on first stall=0 edge.
//  - Reset asserted mid-stall/flush: reset overrides, outputs zero asynchronously.
// CONFIGURATION
//  ID_EX_PERF_EN defined: extra port perf_bubbles out 32 = count of edges where a bubble
//    was loaded (flush, or load with id_valid=0); stall edges not counted; saturates at
//    32'hFFFF_FFFF; cleared by rst_n.
//  ID_EX_PERF_EN undefined: port and counter absent; other behaviour identical.
// TESTING
//  1 reset: rst_n=0 with id_valid=1, id_pc=32'h100 -> ex_valid=0, ex_pc=0, held until rst_n=1.
//  2 load: id_valid=1, id_pc=32'h40, id_ex=3'b101, id_jump_t=11, id_rd=5'd7 -> next edge
//    ex_pc=32'h40, ex_ex=101, ex_jump_t=11, ex_rd=7, ex_valid=1.
//  3 stall: after test 2, stall=1 for 3 edges with id_pc=32'h44 -> ex_pc stays 32'h40;
//    stall=0 -> next edge ex_pc=32'h44.
//  4 flush+stall: stall=1, flush=1, id_reg_write=1 -> ex_valid=0, ex_reg_write=0, ex_jump_t=00.
//  5 async reset mid-operation: rst_n pulled low between edges -> outputs 0 before next edge.
//  6 ID_EX_PERF_EN: 2 flushes + 1 id_valid=0 load + 4 stalls -> perf_bubbles=3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register of the RV32I core: stall holds, flush/invalid loads a bubble.
// Optional bubble counter output perf_bubbles when ID_EX_PERF_EN is defined.
module id_ex_pipe_reg #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_pc_plus4,
   input  logic [XLEN-1:0]    id_rd1,
   input  logic [XLEN-1:0]    id_rd2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [2:0]         id_ex,
   input  logic [1:0]         id_jump_t,
   input  logic               id_slt,
   input  logic               id_lui,
   input  logic               id_reg_write,
   input  logic               id_mem_write,
   input  logic [1:0]         id_result_src,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_pc_plus4,
   output logic [XLEN-1:0]    ex_rd1,
   output logic [XLEN-1:0]    ex_rd2,
   output logic [XLEN-1:0]    ex_imm,
   output logic [RADDR_W-1:0] ex_rs1,
   output logic [RADDR_W-1:0] ex_rs2,
   output logic [RADDR_W-1:0] ex_rd,
   output logic [2:0]         ex_ex,
   output logic [1:0]         ex_jump_t,
   output logic               ex_slt,
   output logic               ex_lui,
   output logic               ex_reg_write,
   output logic               ex_mem_write,
   output logic [1:0]         ex_result_src,
   output logic               ex_valid
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]        perf_bubbles
`endif
);

   logic load_bubble;
   logic load_instr;

   // Flush beats stall; an empty ID slot is treated exactly like a flush.
   assign load_bubble = flush | (~stall & ~id_valid);
   assign load_instr  = ~flush & ~stall & id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_pc         <= '0;
         ex_pc_plus4   <= '0;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_ex         <= '0;
         ex_jump_t     <= '0;
         ex_slt        <= 1'b0;
         ex_lui        <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_result_src <= '0;
         ex_valid      <= 1'b0;
      end else if (load_bubble) begin
         ex_pc         <= '0;
         ex_pc_plus4   <= '0;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_ex         <= '0;
         ex_jump_t     <= '0;
         ex_slt        <= 1'b0;
         ex_lui        <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_result_src <= '0;
         ex_valid      <= 1'b0;
      end else if (load_instr) begin
         ex_pc         <= id_pc;
         ex_pc_plus4   <= id_pc_plus4;
         ex_rd1        <= id_rd1;
         ex_rd2        <= id_rd2;
         ex_imm        <= id_imm;
         ex_rs1        <= id_rs1;
         ex_rs2        <= id_rs2;
         ex_rd         <= id_rd;
         ex_ex         <= id_ex;
         ex_jump_t     <= id_jump_t;
         ex_slt        <= id_slt;
         ex_lui        <= id_lui;
         ex_reg_write  <= id_reg_write;
         ex_mem_write  <= id_mem_write;
         ex_result_src <= id_result_src;
         ex_valid      <= 1'b1;
      end
   end

`ifdef ID_EX_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_bubbles <= '0;
      else if (load_bubble && (perf_bubbles != 32'hFFFF_FFFF))
         perf_bubbles <= perf_bubbles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed cases then random stall/flush/valid traffic
// against a stage-level reference model (bubble, hold or copy of the ID bundle).
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  ex;
      logic [1:0]  jump_t;
      logic        slt;
      logic        lui;
      logic        reg_write;
      logic        mem_write;
      logic [1:0]  result_src;
      logic        valid;
   } stage_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   stall = 1'b0;
   logic   flush = 1'b0;
   stage_t id_s = '0;
   stage_t ex_s;
   stage_t exp_s = '0;

   logic [31:0] ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_ex;
   logic [1:0]  ex_jump_t, ex_result_src;
   logic        ex_slt, ex_lui, ex_reg_write, ex_mem_write, ex_valid;
`ifdef ID_EX_PERF_EN
   logic [31:0] perf_bubbles;
`endif
   logic [31:0] exp_perf = '0;

   int n_checks = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign ex_s = {ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ex,
                  ex_jump_t, ex_slt, ex_lui, ex_reg_write, ex_mem_write, ex_result_src, ex_valid};

   id_ex_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_s.valid), .id_pc(id_s.pc), .id_pc_plus4(id_s.pc_plus4),
      .id_rd1(id_s.rd1), .id_rd2(id_s.rd2), .id_imm(id_s.imm),
      .id_rs1(id_s.rs1), .id_rs2(id_s.rs2), .id_rd(id_s.rd),
      .id_ex(id_s.ex), .id_jump_t(id_s.jump_t), .id_slt(id_s.slt), .id_lui(id_s.lui),
      .id_reg_write(id_s.reg_write), .id_mem_write(id_s.mem_write),
      .id_result_src(id_s.result_src),
      .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ex(ex_ex),
      .ex_jump_t(ex_jump_t), .ex_slt(ex_slt), .ex_lui(ex_lui),
      .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
      .ex_result_src(ex_result_src), .ex_valid(ex_valid)
`ifdef ID_EX_PERF_EN
      , .perf_bubbles(perf_bubbles)
`endif
   );

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: a bubble is the all-zero bundle, a stall keeps EX, otherwise EX mirrors ID.
   function automatic stage_t model_next(stage_t cur, stage_t id, logic fl, logic st);
      if (fl)            return '0;
      if (st)            return cur;
      if (!id.valid)     return '0;
      return id;
   endfunction

   task automatic check_all(input string tag);
      check(tag, {5'b0, ex_s}, {5'b0, exp_s});
      check({tag, "_inv"}, {189'b0, ex_valid ? 3'b000 : {ex_reg_write, ex_mem_write, |ex_jump_t}},
            192'b0);
`ifdef ID_EX_PERF_EN
      check({tag, "_perf"}, {160'b0, perf_bubbles}, {160'b0, exp_perf});
`endif
   endtask

   task automatic step(input string tag);
      stage_t nxt;
      nxt = model_next(exp_s, id_s, flush, stall);
      if (flush || (!stall && !id_s.valid))
         if (exp_perf != 32'hFFFF_FFFF) exp_perf = exp_perf + 1;
      @(posedge clk);
      #1;
      exp_s = nxt;
      check_all(tag);
      $display("cyc %s flush=%0b stall=%0b id_valid=%0b ex_valid=%0b ex_pc=%h",
               tag, flush, stall, id_s.valid, ex_valid, ex_pc);
   endtask

   function automatic stage_t rand_id();
      stage_t s;
      s.pc = $urandom; s.pc_plus4 = $urandom; s.rd1 = $urandom; s.rd2 = $urandom;
      s.imm = $urandom; s.rs1 = 5'($urandom); s.rs2 = 5'($urandom); s.rd = 5'($urandom);
      s.ex = 3'($urandom); s.jump_t = 2'($urandom); s.slt = 1'($urandom);
      s.lui = 1'($urandom); s.reg_write = 1'($urandom); s.mem_write = 1'($urandom);
      s.result_src = 2'($urandom);
      s.valid = ($urandom_range(0, 9) < 8);
      return s;
   endfunction

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      exp_s = '0;
      exp_perf = '0;
      check_all(tag);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // 1: reset holds EX empty even with a valid instruction in ID
      id_s = '0; id_s.valid = 1'b1; id_s.pc = 32'h100;
      #1;
      check_all("rst_async");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all("rst_hold");
      end
      #3 rst_n = 1'b1;

      // 2: plain load
      id_s = '0; id_s.valid = 1'b1; id_s.pc = 32'h40; id_s.ex = 3'b101;
      id_s.jump_t = 2'b11; id_s.rd = 5'd7;
      step("load");
      check("load_pc", {160'b0, ex_pc}, {160'b0, 32'h40});
      check("load_rd", {187'b0, ex_rd}, {187'b0, 5'd7});

      // 3: three stall edges then release
      id_s.pc = 32'h44; stall = 1'b1;
      repeat (3) step("stall");
      check("stall_pc", {160'b0, ex_pc}, {160'b0, 32'h40});
      stall = 1'b0;
      step("unstall");
      check("unstall_pc", {160'b0, ex_pc}, {160'b0, 32'h44});

      // 4: flush beats stall
      stall = 1'b1; flush = 1'b1; id_s.reg_write = 1'b1;
      step("flush_stall");
      check("flush_stall_v", {191'b0, ex_valid}, 192'b0);
      stall = 1'b0; flush = 1'b0;
      step("reload");

      // 5: async reset between edges
      async_reset("rst_mid");

      // 6: 2 flushes + 1 empty load + 4 stalls -> 3 bubbles
      id_s.valid = 1'b1; flush = 1'b1;
      repeat (2) step("perf_flush");
      flush = 1'b0; id_s.valid = 1'b0;
      step("perf_empty");
      stall = 1'b1; id_s.valid = 1'b1;
      repeat (4) step("perf_stall");
      stall = 1'b0;
`ifdef ID_EX_PERF_EN
      check("perf_total", {160'b0, perf_bubbles}, {160'b0, 32'd3});
`endif

      // Random traffic with occasional resets in mid-cycle
      for (int i = 0; i < 300; i++) begin
         id_s = rand_id();
         flush = ($urandom_range(0, 99) < 15);
         stall = ($urandom_range(0, 99) < 25);
         step("rand");
         if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
